// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } md_state_t;

    localparam logic [31:0] NOP_INST       = 32'h0000_0000;
    localparam int          MD_TIMEOUT_DEF = 40;

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Multdiv issue/wait sequencer: start pulses, WAIT-cycle watchdog and result capture.
import hazard_pkg::*;

module md_seq #(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CW         = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic md_rdy,
    input  logic md_exc,
    output logic busy,
    output logic capture,
    output logic exc_out,
    output logic timeout,
    output logic ctrl_mult,
    output logic ctrl_div
);

    md_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        capture    = 1'b0;
        exc_out    = 1'b0;
        timeout    = 1'b0;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    ctrl_div   = is_div;
                    ctrl_mult  = !is_div;
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                busy = 1'b1;
                // A real result wins over the watchdog in the same cycle.
                if (md_rdy) begin
                    capture    = 1'b1;
                    exc_out    = md_exc;
                    state_next = IDLE;
                end else if (cnt_reg == CW'(MD_TIMEOUT - 1)) begin
                    capture    = 1'b1;
                    exc_out    = 1'b1;
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: enable/bubble priority mux, multdiv sequencing and stall counter.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CW         = 6,
    parameter int PERF_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lu_stall,
    input  logic              redirect_x,
    input  logic              md_dx,
    input  logic              md_is_div_dx,
    input  logic              md_rdy,
    input  logic              md_exc,
    output logic              pc_en,
    output logic              fd_en,
    output logic              dx_en,
    output logic              xm_en,
    output logic              mw_en,
    output logic              fd_flush,
    output logic              dx_bubble,
    output logic              xm_bubble,
    output logic              ctrl_mult,
    output logic              ctrl_div,
    output logic              md_capture,
    output logic              md_exc_out,
    output logic              md_timeout,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    logic              seq_busy, seq_capture, seq_exc, seq_timeout, seq_mult, seq_div;
    logic              start;
    logic [4:0]        en_c;
    logic              flush_c, dx_bub_c, xm_bub_c;
    logic [PERF_W-1:0] stall_cnt_reg;

    // A redirect squashes the DX instruction, so it must not issue a multdiv.
    assign start = !seq_busy && md_dx && !redirect_x;

    md_seq #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CW         (CW)
    ) u_md_seq (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_div    (md_is_div_dx),
        .md_rdy    (md_rdy),
        .md_exc    (md_exc),
        .busy      (seq_busy),
        .capture   (seq_capture),
        .exc_out   (seq_exc),
        .timeout   (seq_timeout),
        .ctrl_mult (seq_mult),
        .ctrl_div  (seq_div)
    );

    // en_c bit order: {pc, fd, dx, xm, mw}
    always_comb begin
        en_c     = 5'b11111;
        flush_c  = 1'b0;
        dx_bub_c = 1'b0;
        xm_bub_c = 1'b0;
        if (seq_busy) begin
            if (!seq_capture) begin
                en_c     = 5'b00011;
                xm_bub_c = 1'b1;
            end
        end else if (redirect_x) begin
            flush_c  = 1'b1;
            dx_bub_c = 1'b1;
        end else if (md_dx) begin
            en_c     = 5'b00011;
            xm_bub_c = 1'b1;
        end else if (lu_stall) begin
            en_c     = 5'b00111;
            dx_bub_c = 1'b1;
        end
        if (!reset) begin
            en_c     = 5'b00000;
            flush_c  = 1'b0;
            dx_bub_c = 1'b0;
            xm_bub_c = 1'b0;
        end
    end

    assign {pc_en, fd_en, dx_en, xm_en, mw_en} = en_c;
    assign fd_flush   = flush_c;
    assign dx_bubble  = dx_bub_c;
    assign xm_bubble  = xm_bub_c;
    assign ctrl_mult  = reset && seq_mult;
    assign ctrl_div   = reset && seq_div;
    assign md_capture = reset && seq_capture;
    assign md_exc_out = reset && seq_exc;
    assign md_timeout = reset && seq_timeout;
    assign md_busy    = reset && seq_busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (!en_c[4]) begin
            stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        lu_stall = 0, redirect_x = 0, md_dx = 0, md_is_div_dx = 0, md_rdy = 0, md_exc = 0;
    logic        pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble;
    logic        ctrl_mult, ctrl_div, md_capture, md_exc_out, md_timeout, md_busy;
    logic [31:0] stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    hazard_ctrl #(.MD_TIMEOUT(TO), .CW(6), .PERF_W(32)) dut (
        .clock(clock), .reset(reset), .lu_stall(lu_stall), .redirect_x(redirect_x),
        .md_dx(md_dx), .md_is_div_dx(md_is_div_dx), .md_rdy(md_rdy), .md_exc(md_exc),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_capture(md_capture),
        .md_exc_out(md_exc_out), .md_timeout(md_timeout), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // {pc,fd,dx,xm,mw,fd_flush,dx_bubble,xm_bubble,mult,div,capture,exc_out,timeout,busy}
    function automatic logic [13:0] obs();
        return {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble,
                ctrl_mult, ctrl_div, md_capture, md_exc_out, md_timeout, md_busy};
    endfunction

    // Apply one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic cyc(input logic lu, input logic rd, input logic md, input logic dv,
                       input logic rdy, input logic exc);
        @(posedge clock);
        #1;
        lu_stall = lu; redirect_x = rd; md_dx = md; md_is_div_dx = dv; md_rdy = rdy; md_exc = exc;
        @(negedge clock);
    endtask

    task automatic test_reset();
        md_dx = 1'b1; lu_stall = 1'b1;
        @(negedge clock);
        tests_run++;
        if (obs() !== 14'b0 || stall_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b cnt %0d, want 0 cnt 0", obs(), stall_cnt);
        end
        md_dx = 1'b0; lu_stall = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (obs() !== 14'b11111_000_000_000 || stall_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got %b cnt %0d, want 11111000000000 cnt 0", obs(), stall_cnt);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_load_use();
        cyc(1, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs() !== 14'b00111_010_000_000) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b want 00111010000000", obs());
        end
        cyc(0, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs() !== 14'b11111_000_000_000 || stall_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL load_use_after: got %b cnt %0d want 11111000000000 cnt 1", obs(), stall_cnt);
        end
        $display("[TB] load-use: stall_cnt=%0d", stall_cnt);
    endtask

    // Start an op, let it wait n cycles, release on cycle n with md_rdy (or timeout if rdy=0).
    task automatic run_md(input string name, input logic dv, input int n, input logic rdy,
                          input logic exc, input logic noise, input int exp_cnt);
        int busy_cycles = 0;
        int pulses = 0;
        cyc(0, 0, 1, dv, 0, 0);
        tests_run++;
        if (obs() !== {8'b00011_001, !dv, dv, 4'b0000}) begin
            tests_failed++;
            $display("FAIL %s_start: got %b want %b", name, obs(), {8'b00011_001, !dv, dv, 4'b0000});
        end
        for (int k = 1; k <= n; k++) begin
            cyc(noise, noise, noise, 0, (k == n) ? rdy : 1'b0, exc);
            busy_cycles += md_busy ? 1 : 0;
            pulses += (ctrl_mult || ctrl_div) ? 1 : 0;
            if (k < n) begin
                tests_run++;
                if (obs() !== 14'b00011_001_000_001) begin
                    tests_failed++;
                    $display("FAIL %s_wait%0d: got %b want 00011001000001", name, k, obs());
                end
            end
        end
        tests_run++;
        if (obs() !== {8'b11111_000, 2'b00, 1'b1, rdy ? exc : 1'b1, !rdy, 1'b1}) begin
            tests_failed++;
            $display("FAIL %s_release: got %b want %b", name, obs(),
                     {8'b11111_000, 2'b00, 1'b1, rdy ? exc : 1'b1, !rdy, 1'b1});
        end
        cyc(0, 0, 0, 0, 0, 0);
        tests_run++;
        if (busy_cycles != n || pulses != 0 || md_busy !== 1'b0 || pc_en !== 1'b1
            || stall_cnt !== 32'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL %s_done: busy %0d pulses %0d busy_now %b pc_en %b cnt %0d, want busy %0d pulses 0 0 1 cnt %0d",
                     name, busy_cycles, pulses, md_busy, pc_en, stall_cnt, n, exp_cnt);
        end
        $display("[TB] %s: busy=%0d stall_cnt=%0d", name, busy_cycles, stall_cnt);
    endtask

    task automatic test_mul();      run_md("mul", 0, 17, 1, 0, 0, 18);   endtask
    task automatic test_div_exc();  run_md("div_exc", 1, 33, 1, 1, 0, 51); endtask
    task automatic test_timeout();  run_md("timeout", 0, TO, 0, 0, 1, 91); endtask

    task automatic test_simultaneous();
        cyc(1, 1, 1, 1, 0, 0);
        tests_run++;
        if (obs() !== 14'b11111_110_000_000) begin
            tests_failed++;
            $display("FAIL redirect_priority: got %b want 11111110000000", obs());
        end
        cyc(0, 0, 0, 0, 1, 1);
        tests_run++;
        if (obs() !== 14'b11111_000_000_000 || stall_cnt !== 32'd91) begin
            tests_failed++;
            $display("FAIL rdy_in_idle: got %b cnt %0d want 11111000000000 cnt 91", obs(), stall_cnt);
        end
        $display("[TB] simultaneous redirect/lu/md checked");
        run_md("rdy_at_timeout", 1, TO, 1, 0, 0, 131);
    endtask

    task automatic test_reset_mid_wait();
        cyc(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (obs() !== 14'b0 || stall_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got %b cnt %0d want 0 cnt 0", obs(), stall_cnt);
        end
        @(negedge clock);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 1, 0);
        tests_run++;
        if (obs() !== 14'b11111_000_000_000 || stall_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL late_rdy: got %b cnt %0d want 11111000000000 cnt 0", obs(), stall_cnt);
        end
        cyc(0, 0, 0, 0, 0, 0);
        $display("[TB] reset mid-wait: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_random();
        bit      waiting = 0;
        int      waited  = 0;
        longint  stalls  = 0;
        int      errs    = 0;
        int      ops     = 0;
        for (int i = 0; i < 1500; i++) begin
            logic lu, rd, md, dv, rdy, exc;
            logic [13:0] exp;
            lu  = ($urandom_range(3) == 0);
            rd  = ($urandom_range(5) == 0);
            md  = ($urandom_range(3) == 0);
            dv  = $urandom_range(1);
            rdy = waiting ? ($urandom_range(24) == 0) : ($urandom_range(3) == 0);
            exc = $urandom_range(1);
            if (waiting) begin
                if (rdy || waited + 1 == TO) begin
                    exp = {8'b11111_000, 2'b00, 1'b1, rdy ? exc : 1'b1, !rdy, 1'b1};
                    waiting = 0;
                end else begin
                    exp = 14'b00011_001_000_001;
                    waited++;
                end
            end else if (rd) begin
                exp = 14'b11111_110_000_000;
            end else if (md) begin
                exp = {8'b00011_001, !dv, dv, 4'b0000};
                waiting = 1;
                waited  = 0;
                ops++;
            end else if (lu) begin
                exp = 14'b00111_010_000_000;
            end else begin
                exp = 14'b11111_000_000_000;
            end
            cyc(lu, rd, md, dv, rdy, exc);
            tests_run++;
            if (obs() !== exp || stall_cnt !== 32'(stalls)) begin
                tests_failed++;
                errs++;
                $display("FAIL random_cycle%0d: got %b cnt %0d want %b cnt %0d",
                         i, obs(), stall_cnt, exp, stalls);
            end
            if (!exp[13]) stalls++;
        end
        cyc(0, 0, 0, 0, 0, 0);
        tests_run++;
        if (stall_cnt !== 32'(stalls)) begin
            tests_failed++;
            $display("FAIL random_final_cnt: got %0d want %0d", stall_cnt, stalls);
        end
        $display("[TB] random: 1500 cycles, %0d ops, %0d errors, stall_cnt=%0d", ops, errs, stall_cnt);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_div_exc();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
